board_state: RTL and testbench

- Playfield datapath for the Tetris game; the responder side of the game control FSM's handshake.
- Stores the settled board, one bit per cell, and merges the falling piece into it when update_board_state pulses.
- Reports filled_under and completed_lines back to the FSM, and removes one completed line per shift_down pulse.
- Exposes a row read port for the VGA renderer, plus a cleared-lines counter and a game_over flag.

---
 rtl/board_state.sv | 140 ++++++++++++++
 tb/tb_board_state.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_state.sv
// Tetris playfield datapath: settled board storage, piece merge, contact
// detection, completed-line removal, render read port, line counter and
// the sticky game-over flag. Row 0 is the top row, bit 0 the leftmost column.
module board_state #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear_board,
  input  logic                update_board_state,
  input  logic                shift_down,
  input  logic [4:0]          piece_row,
  input  logic [4*COLS-1:0]   piece_mask,
  input  logic [4:0]          rd_row,
  output logic [COLS-1:0]     rd_data,
  output logic                filled_under,
  output logic [ROWS-1:0]     completed_lines,
  output logic [CNT_W-1:0]    lines_cleared,
  output logic                game_over
);

  // Window row indices are summed in 6 bits so piece_row+3 never wraps.
  localparam logic [5:0] ROWS6 = 6'(ROWS);
  localparam logic [4:0] ROWS5 = 5'(ROWS);

  logic [COLS-1:0]  board_reg [ROWS];
  logic [COLS-1:0]  board_next [ROWS];
  logic [COLS-1:0]  merged [ROWS];
  logic [COLS-1:0]  shifted [ROWS];
  logic [COLS-1:0]  win [4];
  logic [ROWS-1:0]  moves;
  logic [CNT_W-1:0] lines_reg;
  logic [CNT_W-1:0] lines_next;
  logic             over_reg;
  logic             over_next;
  logic             merge_hit;
  logic             fill_hit;
  logic [COLS-1:0]  rd_data_reg;

  genvar gi;

  // Split the flat piece mask into its four window rows.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      assign win[gi] = piece_mask[gi*COLS +: COLS];
    end
  endgenerate

  // A row is complete when every cell is occupied. A row moves down during
  // a shift when it sits at or above the lowest completed row, i.e. when any
  // row at or below it is complete.
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_rows
      assign completed_lines[gi] = &board_reg[gi];
      assign moves[gi] = |completed_lines[ROWS-1:gi];
      if (gi == 0) begin : g_top
        assign shifted[gi] = moves[gi] ? '0 : board_reg[gi];
      end else begin : g_body
        assign shifted[gi] = moves[gi] ? board_reg[gi-1] : board_reg[gi];
      end
    end
  endgenerate

  // Merge the piece window into a copy of the board and flag collisions
  // with occupied cells or any landing in the top row.
  always_comb begin
    logic [5:0] r;
    merged    = board_reg;
    merge_hit = 1'b0;
    r         = '0;
    for (int w = 0; w < 4; w++) begin
      r = 6'(piece_row) + 6'(w);
      if (r < ROWS6) begin
        merged[r[4:0]] = merged[r[4:0]] | win[w];
        if ((win[w] & board_reg[r[4:0]]) != '0) merge_hit = 1'b1;
        if (r == 6'd0 && win[w] != '0) merge_hit = 1'b1;
      end
    end
  end

  // Piece is resting if any occupied window row is on the floor or sits
  // directly above an occupied board cell.
  always_comb begin
    logic [5:0] r;
    logic [5:0] r1;
    fill_hit = 1'b0;
    r        = '0;
    r1       = '0;
    for (int w = 0; w < 4; w++) begin
      r  = 6'(piece_row) + 6'(w);
      r1 = r + 6'd1;
      if (win[w] != '0 && r >= ROWS6 - 6'd1) fill_hit = 1'b1;
      if (r1 < ROWS6) begin
        if ((win[w] & board_reg[r1[4:0]]) != '0) fill_hit = 1'b1;
      end
    end
  end

  // Next-state selection: clear beats merge beats shift; a shift with no
  // completed row leaves everything untouched.
  always_comb begin
    board_next = board_reg;
    lines_next = lines_reg;
    over_next  = over_reg;
    if (clear_board) begin
      for (int i = 0; i < ROWS; i++) board_next[i] = '0;
      lines_next = '0;
      over_next  = 1'b0;
    end else if (update_board_state) begin
      board_next = merged;
      if (merge_hit) over_next = 1'b1;
    end else if (shift_down && (completed_lines != '0)) begin
      board_next = shifted;
      lines_next = lines_reg + CNT_W'(1);
    end
  end

  // State registers and the render read port (reads see the pre-update board).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < ROWS; i++) board_reg[i] <= '0;
      lines_reg   <= '0;
      over_reg    <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      board_reg   <= board_next;
      lines_reg   <= lines_next;
      over_reg    <= over_next;
      rd_data_reg <= (rd_row < ROWS5) ? board_reg[rd_row] : '0;
    end
  end

  assign filled_under  = fill_hit;
  assign lines_cleared = lines_reg;
  assign game_over     = over_reg;
  assign rd_data       = rd_data_reg;

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: reset sweep, floor and stack contact,
// single and double line clears, merge priority, game-over, clear and reset.
module tb_board_state;

  logic          clock;
  logic          resetn;
  logic          clear_board;
  logic          update_board_state;
  logic          shift_down;
  logic [4:0]    piece_row;
  logic [39:0]   piece_mask;
  logic [4:0]    rd_row;
  logic [9:0]    rd_data;
  logic          filled_under;
  logic [19:0]   completed_lines;
  logic [15:0]   lines_cleared;
  logic          game_over;

  int vectors;
  int miscompares;

  board_state dut (
    .clock              (clock),
    .resetn             (resetn),
    .clear_board        (clear_board),
    .update_board_state (update_board_state),
    .shift_down         (shift_down),
    .piece_row          (piece_row),
    .piece_mask         (piece_mask),
    .rd_row             (rd_row),
    .rd_data            (rd_data),
    .filled_under       (filled_under),
    .completed_lines    (completed_lines),
    .lines_cleared      (lines_cleared),
    .game_over          (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_update();
    update_board_state = 1'b1;
    tick();
    update_board_state = 1'b0;
  endtask

  task automatic pulse_shift();
    shift_down = 1'b1;
    tick();
    shift_down = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_board = 1'b1;
    tick();
    clear_board = 1'b0;
  endtask

  task automatic read_row(input string tag, input logic [4:0] r, input logic [9:0] exp);
    rd_row = r;
    tick();
    check_val(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    resetn             = 1'b0;
    clear_board        = 1'b0;
    update_board_state = 1'b0;
    shift_down         = 1'b0;
    piece_row          = 5'd0;
    piece_mask         = '0;
    rd_row             = 5'd0;

    // Reset then read sweep
    tick();
    tick();
    resetn = 1'b1;
    check_val("rst_completed", 32'(completed_lines), 32'h0);
    check_val("rst_lines", 32'(lines_cleared), 32'h0);
    check_val("rst_game_over", 32'(game_over), 32'h0);
    for (int r = 0; r < 20; r++) read_row($sformatf("rst_row%0d", r), 5'(r), 10'h000);
    read_row("rd_out_of_range", 5'd25, 10'h000);

    // Floor contact
    piece_mask = 40'h00_0000_000F;
    piece_row  = 5'd18;
    #1 check_val("floor_row18", 32'(filled_under), 32'h0);
    piece_row  = 5'd19;
    #1 check_val("floor_row19", 32'(filled_under), 32'h1);
    pulse_update();
    read_row("floor_merge_row19", 5'd19, 10'h00F);
    check_val("floor_no_game_over", 32'(game_over), 32'h0);

    // Stack contact
    pulse_clear();
    piece_row  = 5'd10;
    piece_mask = {30'h0, 10'h3FF};
    pulse_update();
    check_val("stack_completed", 32'(completed_lines), 32'h00400);
    piece_mask = {20'h0, 10'h001, 10'h000};
    piece_row  = 5'd8;
    #1 check_val("stack_row8", 32'(filled_under), 32'h1);
    piece_row  = 5'd7;
    #1 check_val("stack_row7", 32'(filled_under), 32'h0);

    // Single clear
    pulse_clear();
    piece_row  = 5'd17;
    piece_mask = {10'h000, 10'h3FF, 10'h155, 10'h2AA};
    pulse_update();
    check_val("single_completed_pre", 32'(completed_lines), 32'h80000);
    pulse_shift();
    check_val("single_completed_post", 32'(completed_lines), 32'h0);
    check_val("single_lines", 32'(lines_cleared), 32'h1);
    read_row("single_row19", 5'd19, 10'h155);
    read_row("single_row18", 5'd18, 10'h2AA);
    read_row("single_row17", 5'd17, 10'h000);
    read_row("single_row0", 5'd0, 10'h000);

    // Double clear
    pulse_clear();
    check_val("clear_lines", 32'(lines_cleared), 32'h0);
    piece_row  = 5'd17;
    piece_mask = {10'h000, 10'h3FF, 10'h3FF, 10'h001};
    pulse_update();
    check_val("double_completed_pre", 32'(completed_lines), 32'hC0000);
    pulse_shift();
    check_val("double_completed_mid", 32'(completed_lines), 32'h80000);
    check_val("double_lines_mid", 32'(lines_cleared), 32'h1);
    read_row("double_row18_mid", 5'd18, 10'h001);
    pulse_shift();
    check_val("double_completed_post", 32'(completed_lines), 32'h0);
    check_val("double_lines", 32'(lines_cleared), 32'h2);
    read_row("double_row19", 5'd19, 10'h001);
    read_row("double_row18", 5'd18, 10'h000);
    pulse_shift();
    check_val("idle_shift_lines", 32'(lines_cleared), 32'h2);
    read_row("idle_shift_row19", 5'd19, 10'h001);

    // Priority: merge wins over shift
    piece_row  = 5'd19;
    piece_mask = {30'h0, 10'h3FE};
    pulse_update();
    check_val("prio_completed_pre", 32'(completed_lines), 32'h80000);
    check_val("prio_game_over_pre", 32'(game_over), 32'h0);
    piece_row  = 5'd16;
    piece_mask = {30'h0, 10'h001};
    update_board_state = 1'b1;
    shift_down         = 1'b1;
    tick();
    update_board_state = 1'b0;
    shift_down         = 1'b0;
    check_val("prio_lines", 32'(lines_cleared), 32'h2);
    check_val("prio_completed_post", 32'(completed_lines), 32'h80000);
    read_row("prio_row16", 5'd16, 10'h001);
    read_row("prio_row19", 5'd19, 10'h3FF);

    // Overlap sets game_over
    pulse_update();
    check_val("overlap_game_over", 32'(game_over), 32'h1);

    // clear_board
    pulse_clear();
    check_val("clr_game_over", 32'(game_over), 32'h0);
    check_val("clr_lines", 32'(lines_cleared), 32'h0);
    check_val("clr_completed", 32'(completed_lines), 32'h0);
    read_row("clr_row19", 5'd19, 10'h000);
    read_row("clr_row16", 5'd16, 10'h000);

    // Window rows past the bottom are discarded
    piece_row  = 5'd19;
    piece_mask = {20'h0, 10'h3FF, 10'h001};
    #1 check_val("discard_filled", 32'(filled_under), 32'h1);
    pulse_update();
    read_row("discard_row19", 5'd19, 10'h001);
    check_val("discard_completed", 32'(completed_lines), 32'h0);
    check_val("discard_game_over", 32'(game_over), 32'h0);

    // Landing in row 0 sets game_over
    piece_row  = 5'd0;
    piece_mask = {30'h0, 10'h010};
    pulse_update();
    check_val("row0_game_over", 32'(game_over), 32'h1);
    read_row("row0_data", 5'd0, 10'h010);

    // Reset overrides a simultaneous merge and shift
    piece_row  = 5'd18;
    piece_mask = {30'h0, 10'h3FF};
    resetn             = 1'b0;
    update_board_state = 1'b1;
    shift_down         = 1'b1;
    tick();
    resetn             = 1'b1;
    update_board_state = 1'b0;
    shift_down         = 1'b0;
    check_val("rst2_game_over", 32'(game_over), 32'h0);
    check_val("rst2_completed", 32'(completed_lines), 32'h0);
    read_row("rst2_row18", 5'd18, 10'h000);
    read_row("rst2_row0", 5'd0, 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
